vga_timing_controller: RTL and testbench

Sequences the 25 MHz pixel-clock horizontal/vertical counters for the 640x480@60 Hz display and decodes them into sync, blanking and coordinate signals for the board renderer. It also owns the frame-update handshake: game logic requests permission to change board state, and the block grants it only inside vertical blanking, so the renderer never sees a half-updated board mid-frame.

---
 rtl/vga_timing_controller.sv | 120 ++++++++++++
 tb/tb_vga_timing_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_controller.sv
// 640x480@60 raster counters with registered sync/blank/coordinate decode,
// plus the vblank-only board-update grant handshake.
module vga_timing_controller #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int GUARD_LINES = 2
) (
  input  logic        clk_25MHz,
  input  logic        rst_n,
  input  logic        upd_req,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        upd_grant,
  output logic        upd_abort
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] X_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] X_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] Y_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [15:0] CLOSE_Y  = 16'(V_TOTAL - GUARD_LINES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GRANT, S_HOLD} upd_state_t;

  upd_state_t  state;
  logic [15:0] next_x;
  logic [15:0] next_y;
  logic        close_pt;
  logic        win_open;

  always_comb begin
    next_x = pixel_x + 16'd1;
    next_y = pixel_y;
    if (pixel_x == X_LAST) begin
      next_x = '0;
      next_y = (pixel_y == Y_LAST) ? '0 : pixel_y + 16'd1;
    end
  end

  // Close point is the edge that moves the raster onto the first guard line;
  // excluding it from the open window keeps a last-cycle grant from
  // skipping the revoke.
  assign close_pt = (next_x == '0) && (next_y == CLOSE_Y);
  assign win_open = (pixel_y >= Y_VIS) && (pixel_y < CLOSE_Y) && !close_pt;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x     <= X_LAST;
      pixel_y     <= Y_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_x     <= next_x;
      pixel_y     <= next_y;
      hsync       <= !((next_x >= HS_START) && (next_x < HS_END));
      vsync       <= !((next_y >= VS_START) && (next_y < VS_END));
      video_on    <= (next_x < X_VIS) && (next_y < Y_VIS);
      line_start  <= (next_x == '0);
      frame_start <= (next_x == '0) && (next_y == '0);
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      upd_grant <= 1'b0;
      upd_abort <= 1'b0;
    end else begin
      upd_abort <= 1'b0;
      case (state)
        S_IDLE: if (upd_req) state <= S_WAIT;
        S_WAIT: begin
          if (!upd_req) begin
            state <= S_IDLE;
          end else if (win_open) begin
            state     <= S_GRANT;
            upd_grant <= 1'b1;
          end
        end
        S_GRANT: begin
          if (!upd_req) begin
            state     <= S_IDLE;
            upd_grant <= 1'b0;
          end else if (close_pt) begin
            state     <= S_HOLD;
            upd_grant <= 1'b0;
            upd_abort <= 1'b1;
          end
        end
        S_HOLD: if (!upd_req) state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          upd_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: a reduced-geometry instance for frame/handshake scenarios
// and a full 640x480 instance for reset values and one-line decode.
module tb_vga_timing_controller;

  localparam int HV = 20, HF = 4, HS = 6, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 3, VS = 2, VB = 4, VT = VV + VF + VS + VB;
  localparam int CLOSE = VT - 2;
  localparam int FRAME = HT * VT;

  logic clk_25MHz = 1'b0;
  logic rst_n = 1'b0;
  logic upd_req = 1'b0;

  logic        s_hsync, s_vsync, s_video_on, s_ls, s_fs, s_grant, s_abort;
  logic [15:0] s_px, s_py;
  logic        f_hsync, f_vsync, f_video_on, f_ls, f_fs, f_grant, f_abort;
  logic [15:0] f_px, f_py;

  int errors = 0;
  int checks = 0;

  always #20 clk_25MHz = ~clk_25MHz;

  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .GUARD_LINES(2)
  ) dut (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .upd_req(upd_req),
    .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on),
    .pixel_x(s_px), .pixel_y(s_py), .line_start(s_ls), .frame_start(s_fs),
    .upd_grant(s_grant), .upd_abort(s_abort)
  );

  vga_timing_controller dut_full (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .upd_req(upd_req),
    .hsync(f_hsync), .vsync(f_vsync), .video_on(f_video_on),
    .pixel_x(f_px), .pixel_y(f_py), .line_start(f_ls), .frame_start(f_fs),
    .upd_grant(f_grant), .upd_abort(f_abort)
  );

  task automatic tick();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(s_px == x && s_py == y) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("FAIL wait_xy timeout: at (%0d,%0d), wanted (%0d,%0d)", s_px, s_py, x, y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    upd_req = 1'b0;
    repeat (5) tick();
    checks++;
    if ({s_px, s_py} !== {16'd31, 16'd20}) begin
      errors++; $display("FAIL reset_counters: got (%0d,%0d) want (31,20)", s_px, s_py);
    end
    checks++;
    if ({s_hsync, s_vsync, s_video_on, s_ls, s_fs, s_grant, s_abort} !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1100000",
               {s_hsync, s_vsync, s_video_on, s_ls, s_fs, s_grant, s_abort});
    end
    checks++;
    if ({f_px, f_py} !== {16'd799, 16'd524}) begin
      errors++; $display("FAIL reset_full_counters: got (%0d,%0d) want (799,524)", f_px, f_py);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({s_px, s_py, s_video_on, s_ls, s_fs, s_hsync} !== {16'd0, 16'd0, 4'b1111}) begin
      errors++;
      $display("FAIL first_edge: got (%0d,%0d) vid=%b ls=%b fs=%b hs=%b want (0,0) 1111",
               s_px, s_py, s_video_on, s_ls, s_fs, s_hsync);
    end
    checks++;
    if ({f_px, f_py, f_video_on, f_fs} !== {16'd0, 16'd0, 2'b11}) begin
      errors++;
      $display("FAIL first_edge_full: got (%0d,%0d) vid=%b fs=%b want (0,0) 11",
               f_px, f_py, f_video_on, f_fs);
    end
  endtask

  task automatic test_full_line();
    int bad = 0, hs_low = 0, hs_first = -1, vid = 0;
    for (int i = 0; i < 800; i++) begin
      if (f_px !== 16'(i) || f_py !== 16'd0) bad++;
      if (f_hsync !== !(i >= 656 && i < 752)) bad++;
      if (f_video_on !== (i < 640)) bad++;
      if (f_hsync === 1'b0) begin
        if (hs_first < 0) hs_first = i;
        hs_low++;
      end
      if (f_video_on === 1'b1) vid++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL full_line_decode: %0d bad cycles want 0", bad); end
    checks++;
    if (hs_low != 96 || hs_first != 656) begin
      errors++; $display("FAIL full_hsync: low=%0d first=%0d want 96/656", hs_low, hs_first);
    end
    checks++;
    if (vid != 640) begin errors++; $display("FAIL full_video_on: got %0d want 640", vid); end
    checks++;
    if ({f_px, f_py, f_ls, f_fs} !== {16'd0, 16'd1, 2'b10}) begin
      errors++;
      $display("FAIL full_line_wrap: got (%0d,%0d) ls=%b fs=%b want (0,1) 10", f_px, f_py, f_ls, f_fs);
    end
  endtask

  task automatic test_frame_decode();
    int mx = 0, my = 0, bad = 0, vs_low = 0, lines = 0, period = -1;
    logic ehs, evs, evid;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c <= FRAME; c++) begin
      ehs  = !(mx >= HV + HF && mx < HV + HF + HS);
      evs  = !(my >= VV + VF && my < VV + VF + VS);
      evid = (mx < HV) && (my < VV);
      if ({s_px, s_py} !== {16'(mx), 16'(my)}) bad++;
      if ({s_hsync, s_vsync, s_video_on, s_ls, s_fs} !== {ehs, evs, evid, mx == 0, mx == 0 && my == 0})
        bad++;
      if (c < FRAME && s_vsync === 1'b0) vs_low++;
      if (c < FRAME && s_ls === 1'b1) lines++;
      if (c > 0 && period < 0 && s_fs === 1'b1) period = c;
      if (c < FRAME) begin
        mx++;
        if (mx == HT) begin
          mx = 0;
          my = (my == VT - 1) ? 0 : my + 1;
        end
        tick();
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frame_decode: %0d bad cycles want 0", bad); end
    checks++;
    if (period != FRAME) begin errors++; $display("FAIL frame_period: got %0d want %0d", period, FRAME); end
    checks++;
    if (vs_low != VS * HT) begin errors++; $display("FAIL vsync_width: got %0d want %0d", vs_low, VS * HT); end
    checks++;
    if (lines != VT) begin errors++; $display("FAIL line_count: got %0d want %0d", lines, VT); end
  endtask

  task automatic test_visible_request();
    int n = 0, early = 0;
    wait_xy(0, 3);
    upd_req = 1'b1;
    while (!(s_px == 1 && s_py == VV) && n < 2 * FRAME) begin
      if (s_grant !== 1'b0) early++;
      tick();
      n++;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL visible_early_grant: %0d cycles want 0", early); end
    checks++;
    if (s_grant !== 1'b1 || s_abort !== 1'b0) begin
      errors++; $display("FAIL visible_grant_rise: grant=%b abort=%b want 1/0", s_grant, s_abort);
    end
    wait_xy(0, VV + 5);
    upd_req = 1'b0;
    tick();
    checks++;
    if (s_grant !== 1'b0 || s_abort !== 1'b0) begin
      errors++; $display("FAIL visible_release: grant=%b abort=%b want 0/0", s_grant, s_abort);
    end
  endtask

  task automatic test_forced_revoke();
    int bad = 0, aborts = 0;
    bit second = 0;
    logic eg, ea;
    wait_xy(0, 5);
    upd_req = 1'b1;
    for (int i = 0; i < FRAME + 9 * HT + 5; i++) begin
      tick();
      if (s_px == 0 && s_py == 0) second = 1;
      eg = !second && ((s_py == VV && s_px >= 1) || (s_py > VV && s_py < CLOSE));
      ea = !second && s_px == 0 && s_py == CLOSE;
      if (s_grant !== eg || s_abort !== ea) bad++;
      if (s_abort === 1'b1) aborts++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL revoke_trace: %0d bad cycles want 0", bad); end
    checks++;
    if (aborts != 1) begin errors++; $display("FAIL revoke_abort_count: got %0d want 1", aborts); end
    upd_req = 1'b0;
    tick();
    upd_req = 1'b1;
    tick();
    checks++;
    if (s_grant !== 1'b0) begin errors++; $display("FAIL regrant_wait: grant=%b want 0", s_grant); end
    tick();
    checks++;
    if (s_grant !== 1'b1) begin errors++; $display("FAIL regrant_after_toggle: grant=%b want 1", s_grant); end
  endtask

  task automatic test_close_drop_same_cycle();
    wait_xy(HT - 1, CLOSE - 1);
    checks++;
    if (s_grant !== 1'b1) begin errors++; $display("FAIL close_drop_pre: grant=%b want 1", s_grant); end
    upd_req = 1'b0;
    tick();
    checks++;
    if (s_grant !== 1'b0 || s_abort !== 1'b0) begin
      errors++; $display("FAIL close_drop: grant=%b abort=%b want 0/0", s_grant, s_abort);
    end
  endtask

  task automatic test_late_request();
    int n = 0;
    bit wrapped = 0;
    wait_xy(3, CLOSE);
    upd_req = 1'b1;
    while (s_grant !== 1'b1 && n < 2 * FRAME) begin
      tick();
      if (s_py == 0) wrapped = 1;
      n++;
    end
    checks++;
    if (!wrapped || {s_px, s_py} !== {16'd1, 16'(VV)}) begin
      errors++;
      $display("FAIL late_request: grant at (%0d,%0d) wrapped=%0b want (1,%0d) 1", s_px, s_py, wrapped, VV);
    end
    upd_req = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    wait_xy(0, 5);
    upd_req = 1'b1;
    wait_xy(0, VV + 4);
    checks++;
    if (s_grant !== 1'b1) begin errors++; $display("FAIL async_pre_grant: grant=%b want 1", s_grant); end
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_grant, s_abort} !== 2'b00 || {s_px, s_py} !== {16'd31, 16'd20}) begin
      errors++;
      $display("FAIL async_reset: grant=%b abort=%b (%0d,%0d) want 0 0 (31,20)", s_grant, s_abort, s_px, s_py);
    end
    checks++;
    if ({f_px, f_py} !== {16'd799, 16'd524}) begin
      errors++; $display("FAIL async_reset_full: got (%0d,%0d) want (799,524)", f_px, f_py);
    end
    tick();
    checks++;
    if ({s_grant, s_abort} !== 2'b00) begin
      errors++; $display("FAIL async_hold: grant=%b abort=%b want 00", s_grant, s_abort);
    end
    upd_req = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({s_px, s_py, s_fs} !== {16'd0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL async_release: got (%0d,%0d) fs=%b want (0,0) 1", s_px, s_py, s_fs);
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_frame_decode();
    test_visible_request();
    test_forced_revoke();
    test_close_drop_same_cycle();
    test_late_request();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
